// File: rtl/stack_lifo_pkg.sv
// Shared types for the operand stack: the per-cycle operation decode used by
// the top level to steer pointer and write-enable updates.
package stack_lifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE,
    OP_PUSH,
    OP_POP,
    OP_REPLACE
  } stack_op_e;

  // Push+pop on a non-empty stack swaps the top word, even when full; push+pop
  // on an empty stack degrades to a plain push. Everything illegal is dropped.
  function automatic stack_op_e decode_op(input logic push, input logic pop,
                                          input logic full, input logic empty);
    if (push && pop && !empty) return OP_REPLACE;
    if (push && !full)         return OP_PUSH;
    if (pop && !push && !empty) return OP_POP;
    return OP_IDLE;
  endfunction

endpackage

// File: rtl/stack_lifo_register.sv
// WIDTH-bit storage register with load enable and asynchronous active-low
// clear; used for every stack slot and for the read-data register.
module register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: storage words are cleared by reset too, so a fresh stack never holds
  // stale data from before the reset; sequential state uses <= only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/stack_lifo.sv
// LIFO operand stack: DEPTH slots of WIDTH bits, occupancy pointer, full/empty
// flags and a registered read port loaded only by accepted pops.
module stack_lifo
  import stack_lifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic [DEPTH-1:0] pointer
);

  localparam int PTR_W = DEPTH;

  if ((WIDTH % 4) != 0 || DEPTH < 2) begin : g_bad_param
    $error("stack_lifo: WIDTH must be a multiple of 4 and DEPTH >= 2");
  end

  logic [PTR_W-1:0] r_pointer;
  logic [WIDTH-1:0] w_mem [DEPTH];
  logic [WIDTH-1:0] w_top;
  logic [DEPTH-1:0] w_wr_en;
  logic             w_rd_en;
  stack_op_e        w_op;

  assign full    = (r_pointer == PTR_W'(DEPTH));
  assign empty   = (r_pointer == '0);
  assign pointer = r_pointer;

  assign w_op    = decode_op(push, pop, full, empty);
  assign w_rd_en = (w_op == OP_POP) || (w_op == OP_REPLACE);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_wr_en = '0;
    for (int i = 0; i < DEPTH; i++) begin
      case (w_op)
        OP_PUSH:    w_wr_en[i] = (r_pointer == PTR_W'(i));
        OP_REPLACE: w_wr_en[i] = (r_pointer == PTR_W'(i + 1));
        default:    w_wr_en[i] = 1'b0;
      endcase
    end
  end

  // Top-of-stack select compares against pointer-1 without ever forming an
  // out-of-range index when the stack is empty.
  always_comb begin
    w_top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_pointer == PTR_W'(i + 1)) w_top = w_mem[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pointer <= '0;
    end else begin
      case (w_op)
        OP_PUSH: r_pointer <= r_pointer + PTR_W'(1);
        OP_POP:  r_pointer <= r_pointer - PTR_W'(1);
        default: r_pointer <= r_pointer;
      endcase
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    register #(.WIDTH(WIDTH)) u_slot (
      .clk (clk),
      .rst (rst),
      .en  (w_wr_en[g]),
      .d   (data_in),
      .q   (w_mem[g])
    );
  end

  register #(.WIDTH(WIDTH)) u_data_out (
    .clk (clk),
    .rst (rst),
    .en  (w_rd_en),
    .d   (w_top),
    .q   (data_out)
  );

endmodule

// File: tb/tb_stack_lifo.sv
// Self-checking bench for stack_lifo: a behavioural stack model feeds a
// scoreboard of expected popped words, compared one cycle after each pop.
module tb_stack_lifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk;
  logic             rst;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic [DEPTH-1:0] pointer;

  int n_checks = 0;
  int n_errors = 0;

  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] sb_q[$];
  logic [WIDTH-1:0] model_dout;

  stack_lifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .data_in  (data_in),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
    .pointer  (pointer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "/pointer"}, 32'(pointer), 32'(model_q.size()));
    check({tag, "/full"},    32'(full),    32'(model_q.size() == DEPTH));
    check({tag, "/empty"},   32'(empty),   32'(model_q.size() == 0));
    check({tag, "/dout"},    32'(data_out), 32'(model_dout));
  endtask

  task automatic do_op(input string tag, input logic p, input logic q, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] popped;
    @(negedge clk);
    push    = p;
    pop     = q;
    data_in = d;
    if (p && q && model_q.size() > 0) begin
      popped = model_q[model_q.size() - 1];
      model_q[model_q.size() - 1] = d;
      sb_q.push_back(popped);
      model_dout = popped;
    end else if (p && model_q.size() < DEPTH) begin
      model_q.push_back(d);
    end else if (q && !p && model_q.size() > 0) begin
      popped = model_q.pop_back();
      sb_q.push_back(popped);
      model_dout = popped;
    end
    @(posedge clk);
    #1;
    push = 1'b0;
    pop  = 1'b0;
    if (sb_q.size() > 0) check({tag, "/popped"}, 32'(data_out), 32'(sb_q.pop_front()));
    check_state(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    model_q.delete();
    sb_q.delete();
    model_dout = '0;
    check_state(tag);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst        = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    data_in    = '0;
    model_dout = '0;
    #2;
    check_state("reset");
    @(negedge clk);
    rst = 1'b1;

    // Fill, then drain in reverse order.
    do_op("push_aa", 1, 0, 8'hAA);
    do_op("push_bb", 1, 0, 8'hBB);
    do_op("push_cc", 1, 0, 8'hCC);
    do_op("pop_1",   0, 1, 8'h00);
    do_op("pop_2",   0, 1, 8'h00);
    do_op("pop_3",   0, 1, 8'h00);

    // Push while full is dropped.
    do_op("refill_aa", 1, 0, 8'hAA);
    do_op("refill_bb", 1, 0, 8'hBB);
    do_op("refill_cc", 1, 0, 8'hCC);
    do_op("push_full", 1, 0, 8'hDD);
    do_op("drain_1",   0, 1, 8'h00);
    do_op("drain_2",   0, 1, 8'h00);
    do_op("drain_3",   0, 1, 8'h00);

    // Pop on empty holds data_out; replace-top and push+pop on empty.
    do_op("pop_empty",   0, 1, 8'h00);
    do_op("pushpop_empty", 1, 1, 8'h55);
    do_op("pop_55",      0, 1, 8'h00);
    do_op("push_11",     1, 0, 8'h11);
    do_op("replace_22",  1, 1, 8'h22);
    do_op("pop_22",      0, 1, 8'h00);

    // Replace top while full, then confirm the rest of the stack survived.
    do_op("fill_1",      1, 0, 8'h01);
    do_op("fill_2",      1, 0, 8'h02);
    do_op("fill_3",      1, 0, 8'h03);
    do_op("replace_full", 1, 1, 8'h7E);
    do_op("rf_pop_1",    0, 1, 8'h00);
    do_op("rf_pop_2",    0, 1, 8'h00);
    do_op("rf_pop_3",    0, 1, 8'h00);

    // Asynchronous reset between edges with two entries held.
    do_op("pre_rst_33", 1, 0, 8'h33);
    do_op("pre_rst_44", 1, 0, 8'h44);
    do_op("pre_rst_pop", 0, 1, 8'h00);
    do_op("pre_rst_55", 1, 0, 8'h55);
    async_reset("async_rst");

    // Back-to-back random strobes.
    for (int i = 0; i < 80; i++) begin
      do_op("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            WIDTH'($urandom_range(0, 255)));
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
